// File: rtl/modop_stream_pkg.sv
// Shared definitions for the modular-arithmetic stream engine:
// op codes, default sizes, pipeline depths and lane packing.
`define MODOP_LANE(v, i, w) v[((i)+1)*(w)-1 -: (w)]

package modop_stream_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_MAC = 2'd3
    } op_e;

    localparam int INTMUL_DELAY     = 2;
    localparam int MODRED_DELAY     = 4;
    localparam int DEF_WIDTH        = 32;
    localparam int DEF_LANES        = 16;
    localparam int DEF_NUM_MOD      = 8;
    localparam int DEF_MODMUL_DELAY = INTMUL_DELAY + MODRED_DELAY;

endpackage

// File: rtl/modop_lane.sv
// One lane of the modular datapath: operand stage, reduction delay
// line and the final op/accumulate stage.
module modop_lane
    import modop_stream_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int MODMUL_DELAY = DEF_MODMUL_DELAY
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] s0_q,
    input  op_e              s0_op,
    input  logic             fin_en,
    input  op_e              fin_op,
    input  logic             fin_first,
    input  logic [WIDTH-1:0] fin_q,
    output logic [WIDTH-1:0] res,
    output logic             res_err
);

    localparam int D = MODMUL_DELAY;

    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   b0;
    logic [WIDTH-1:0]   val0;
    logic               bad0;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [WIDTH-1:0]   dv [1:D-1];
    logic               db [1:D-1];
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH:0]     acc_sum;

    always_ff @(posedge clk) begin
        if (in_en) begin
            a0 <= in_a;
            b0 <= in_b;
        end
    end

    always_comb begin
        prod = {{WIDTH{1'b0}}, a0} * {{WIDTH{1'b0}}, b0};
        sum  = {1'b0, a0} + {1'b0, b0};
        dif  = (a0 >= b0) ? {1'b0, a0 - b0}
                          : {1'b0, a0} + {1'b0, s0_q} - {1'b0, b0};
        bad0 = (a0 >= s0_q) || (b0 >= s0_q) || (s0_q < WIDTH'(2));
        val0 = '0;
        unique case (1'b1)
            (s0_op == OP_ADD):
                val0 = (sum >= {1'b0, s0_q}) ? WIDTH'(sum - {1'b0, s0_q})
                                             : WIDTH'(sum);
            (s0_op == OP_SUB):
                val0 = WIDTH'(dif);
            default:
                val0 = WIDTH'(prod % {{WIDTH{1'b0}}, s0_q});
        endcase
    end

    // Free-running delay line; the beat's valid travels in the top.
    always_ff @(posedge clk) begin
        dv[1] <= val0;
        db[1] <= bad0;
        for (int i = 2; i < D; i++) begin
            dv[i] <= dv[i-1];
            db[i] <= db[i-1];
        end
    end

    always_comb begin
        base    = fin_first ? '0 : acc;
        acc_sum = {1'b0, base} + {1'b0, dv[D-1]};
        acc_nx  = WIDTH'(acc_sum % {1'b0, fin_q});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (fin_en && fin_op == OP_MAC && !db[D-1]) begin
            acc <= acc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (fin_en) begin
            res_err <= db[D-1];
            if (db[D-1]) begin
                res <= '0;
            end else if (fin_op == OP_MAC) begin
                res <= acc_nx;
            end else begin
                res <= dv[D-1];
            end
        end
    end

endmodule

// File: rtl/modop_stream.sv
// Multi-lane modular MUL/ADD/SUB/MAC stream with modulus table,
// credit-based input flow control and a FWFT output buffer.
module modop_stream
    import modop_stream_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LANES        = DEF_LANES,
    parameter int NUM_MOD      = DEF_NUM_MOD,
    parameter int MODMUL_DELAY = DEF_MODMUL_DELAY,
    parameter int OBUF_DEPTH   = MODMUL_DELAY + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_MOD)-1:0] cfg_idx,
    input  logic [WIDTH-1:0]           cfg_modulus,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic                       in_first,
    input  logic [$clog2(NUM_MOD)-1:0] in_mod_sel,
    input  logic [WIDTH*LANES-1:0]     in_a,
    input  logic [WIDTH*LANES-1:0]     in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*LANES-1:0]     out_data,
    output logic                       busy,
    output logic                       err_range,
    input  logic                       err_clr
);

    localparam int D  = MODMUL_DELAY;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int DW = WIDTH * LANES;

    logic [WIDTH-1:0] mtab [NUM_MOD];
    logic [D:0]       vld;
    op_e              op_p    [D];
    logic             first_p [D];
    logic [WIDTH-1:0] q_p     [D];
    logic [DW-1:0]    res;
    logic [LANES-1:0] res_err;
    logic [DW-1:0]    fifo [OBUF_DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    fcnt;
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             fire;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover pipeline plus buffer, so the buffer never overflows.
    assign in_ready  = reset && (cnt < CW'(OBUF_DEPTH));
    assign fire      = in_valid && in_ready;
    assign out_valid = (fcnt != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo[rp];
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MOD; i++) begin
                mtab[i] <= '0;
            end
        end else if (cfg_we) begin
            mtab[cfg_idx] <= cfg_modulus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
        end else begin
            vld <= {vld[D-1:0], fire};
        end
    end

    // Modulus is captured with the beat so later table writes miss it.
    always_ff @(posedge clk) begin
        if (fire) begin
            op_p[0]    <= op_e'(in_op);
            first_p[0] <= in_first;
            q_p[0]     <= mtab[in_mod_sel];
        end
        for (int i = 1; i < D; i++) begin
            op_p[i]    <= op_p[i-1];
            first_p[i] <= first_p[i-1];
            q_p[i]     <= q_p[i-1];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        modop_lane #(
            .WIDTH        (WIDTH),
            .MODMUL_DELAY (D)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .in_en     (fire),
            .in_a      (`MODOP_LANE(in_a, l, WIDTH)),
            .in_b      (`MODOP_LANE(in_b, l, WIDTH)),
            .s0_q      (q_p[0]),
            .s0_op     (op_p[0]),
            .fin_en    (vld[D-1]),
            .fin_op    (op_p[D-1]),
            .fin_first (first_p[D-1]),
            .fin_q     (q_p[D-1]),
            .res       (`MODOP_LANE(res, l, WIDTH)),
            .res_err   (res_err[l])
        );
    end

    always_ff @(posedge clk) begin
        if (vld[D]) begin
            fifo[wp] <= res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            fcnt      <= '0;
            wp        <= '0;
            rp        <= '0;
            err_range <= 1'b0;
        end else begin
            cnt  <= cnt + CW'(fire) - CW'(pop);
            fcnt <= fcnt + CW'(vld[D]) - CW'(pop);
            if (vld[D]) begin
                wp <= ptr_inc(wp);
            end
            if (pop) begin
                rp <= ptr_inc(rp);
            end
            if (vld[D] && (|res_err)) begin
                err_range <= 1'b1;
            end else if (err_clr) begin
                err_range <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modop_stream.sv
// Self-checking bench for modop_stream: vector table, scoreboard,
// backpressure, error flag, cfg timing, random traffic and reset.
module tb_modop_stream;

    localparam int W  = 32;
    localparam int L  = 16;
    localparam int NM = 8;
    localparam int D  = 6;
    localparam int OD = D + 2;
    localparam int DW = W * L;
    localparam logic [31:0] Q = 32'd4244570881;

    logic          clk;
    logic          reset;
    logic          cfg_we;
    logic [2:0]    cfg_idx;
    logic [W-1:0]  cfg_modulus;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic          in_first;
    logic [2:0]    in_mod_sel;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          err_range;
    logic          err_clr;

    modop_stream #(
        .WIDTH        (W),
        .LANES        (L),
        .NUM_MOD      (NM),
        .MODMUL_DELAY (D),
        .OBUF_DEPTH   (OD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_modulus (cfg_modulus),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_first    (in_first),
        .in_mod_sel  (in_mod_sel),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .err_range   (err_range),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        first;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;
    logic [DW-1:0] sb [$];
    logic [31:0]   qtab [NM];
    logic [31:0]   macc [L];
    bit            rnd_on;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] uni(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int l = 0; l < L; l++) r[l*W +: W] = v;
        return r;
    endfunction

    function automatic logic [31:0] mref(input logic [1:0] op,
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] q, input logic [31:0] acc);
        logic [63:0] x, y, m, c;
        x = a; y = b; m = q; c = acc;
        case (op)
            2'd0:    return 32'((x * y) % m);
            2'd1:    return 32'((x + y) % m);
            2'd2:    return 32'((x + m - y) % m);
            default: return 32'((c + (x * y) % m) % m);
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected none", out_data);
            end else begin
                check("beat", out_data, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic first,
                        input logic [2:0] sel, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp);
        in_valid   = 1'b1;
        in_op      = op;
        in_first   = first;
        in_mod_sel = sel;
        in_a       = a;
        in_b       = b;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1");
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d pending expected 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [31:0] v);
        cfg_we      = 1'b1;
        cfg_idx     = idx;
        cfg_modulus = v;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        qtab[idx] = v;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    vec_t          vt [10];
    int            lat;
    int            p0;
    bit            seen;
    logic [1:0]    rop;
    logic          rfirst;
    logic [2:0]    rsel;
    logic [31:0]   q;
    logic [31:0]   av;
    logic [31:0]   bv;
    logic [31:0]   r;
    int            badlane;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] rexp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'd0, 1'b0, 32'd2,  32'd3,  32'd6};
        vt[1] = '{2'd0, 1'b0, Q - 1,  Q - 1,  32'd1};
        vt[2] = '{2'd2, 1'b0, 32'd0,  32'd1,  Q - 1};
        vt[3] = '{2'd1, 1'b0, Q - 1,  32'd1,  32'd0};
        vt[4] = '{2'd3, 1'b1, 32'd2,  32'd3,  32'd6};
        vt[5] = '{2'd3, 1'b0, 32'd4,  32'd5,  32'd26};
        vt[6] = '{2'd3, 1'b1, 32'd1,  32'd1,  32'd1};
        vt[7] = '{2'd1, 1'b0, 32'd5,  32'd7,  32'd12};
        vt[8] = '{2'd2, 1'b0, 32'd7,  32'd5,  32'd2};
        vt[9] = '{2'd0, 1'b0, 32'd0,  Q - 1,  32'd0};
        for (int i = 0; i < NM; i++) qtab[i] = '0;

        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_modulus = '0;
        in_valid = 1'b0; in_op = '0; in_first = 1'b0; in_mod_sel = '0;
        in_a = '0; in_b = '0; out_ready = 1'b1; err_clr = 1'b0;
        #12;
        check_int("rst_in_ready", in_ready, 0);
        check_int("rst_out_valid", out_valid, 0);
        check_int("rst_busy", busy, 0);
        check_int("rst_err", err_range, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_int("ready_after_release", in_ready, 1);
        @(posedge clk);
        #1;
        cfg(3'd0, Q);
        cfg(3'd1, 32'd97);

        for (int i = 0; i < 10; i++)
            send(vt[i].op, vt[i].first, 3'd0, uni(vt[i].a), uni(vt[i].b),
                 uni(vt[i].e));
        drain("table_drain");

        send(2'd0, 1'b0, 3'd0, uni(32'd7), uni(32'd9), uni(32'd63));
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            @(posedge clk);
        end
        check_int("latency", lat, D + 1);
        drain("latency_drain");

        out_ready = 1'b0;
        for (int k = 1; k <= OD; k++)
            send(2'd0, 1'b0, 3'd0, uni(32'(k)), uni(32'd1), uni(32'(k)));
        in_valid = 1'b1;
        in_a = uni(32'(OD + 1));
        in_b = uni(32'd1);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        check_int("full_in_ready", seen, 0);
        check_int("stall_valid", out_valid, 1);
        check("stall_hold", out_data, sb[0]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        p0 = pops;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_int("release_count", pops - p0, OD);
        for (int k = OD + 1; k <= OD + 2; k++)
            send(2'd0, 1'b0, 3'd0, uni(32'(k)), uni(32'd1), uni(32'(k)));
        drain("bp_drain");

        clear_err();
        check_int("err_clear0", err_range, 0);
        ra = uni(32'd1);
        ra[3*W +: W] = Q;
        rexp = uni(32'd2);
        rexp[3*W +: W] = '0;
        send(2'd1, 1'b0, 3'd0, ra, uni(32'd1), rexp);
        drain("err_drain");
        check_int("err_set", err_range, 1);
        repeat (3) @(posedge clk);
        #1;
        check_int("err_sticky", err_range, 1);
        clear_err();
        check_int("err_cleared", err_range, 0);
        send(2'd1, 1'b0, 3'd0, ra, uni(32'd1), rexp);
        repeat (D) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_int("err_set_wins", err_range, 1);
        drain("err2_drain");
        clear_err();
        send(2'd1, 1'b0, 3'd2, uni(32'd0), uni(32'd0), uni(32'd0));
        drain("qsmall_drain");
        check_int("err_q_small", err_range, 1);
        clear_err();
        check_int("err_cleared2", err_range, 0);

        cfg_we = 1'b1;
        cfg_idx = 3'd1;
        cfg_modulus = 32'd101;
        send(2'd1, 1'b0, 3'd1, uni(32'd90), uni(32'd10), uni(32'd3));
        cfg_we = 1'b0;
        qtab[1] = 32'd101;
        send(2'd1, 1'b0, 3'd1, uni(32'd90), uni(32'd10), uni(32'd100));
        send(2'd0, 1'b0, 3'd1, uni(32'd100), uni(32'd100), uni(32'd1));
        drain("cfg_drain");

        for (int l = 0; l < L; l++) macc[l] = 32'd1;
        p0 = pops;
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    rop = 2'($urandom % 4);
                    rsel = 3'($urandom % 2);
                    q = qtab[rsel];
                    rfirst = ($urandom % 8 == 0);
                    badlane = ($urandom % 16 == 0) ? int'($urandom % L) : -1;
                    for (int l = 0; l < L; l++) begin
                        av = ($urandom % 8 == 0) ? q - 1 : $urandom % q;
                        bv = ($urandom % 8 == 0) ? q - 1 : $urandom % q;
                        if (l == badlane) av = q;
                        ra[l*W +: W] = av;
                        rb[l*W +: W] = bv;
                        if (av >= q || bv >= q) begin
                            rexp[l*W +: W] = '0;
                        end else begin
                            r = mref(rop, av, bv, q, rfirst ? 32'd0 : macc[l]);
                            rexp[l*W +: W] = r;
                            if (rop == 2'd3) macc[l] = r;
                        end
                    end
                    send(rop, rfirst, rsel, ra, rb, rexp);
                    if ($urandom % 4 == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom % 3 != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("rand_drain");
        check_int("rand_count", pops - p0, 1000);

        for (int i = 0; i < 4; i++)
            send(2'd0, 1'b0, 3'd0, uni(32'(i + 1)), uni(32'd1), uni(32'(i + 1)));
        reset = 1'b0;
        #1;
        check_int("midrst_out_valid", out_valid, 0);
        check_int("midrst_busy", busy, 0);
        check_int("midrst_in_ready", in_ready, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_int("midrst_ready_after", in_ready, 1);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check_int("midrst_no_stale", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modop_stream.md
MODOP_STREAM -- requirements
Module: modop_stream

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, coefficient/modulus width; LANES, default 16, parallel lanes; NUM_MOD, default 8, modulus table entries; MODMUL_DELAY, default 6, modular-multiplier pipeline depth; OBUF_DEPTH, default MODMUL_DELAY+2, output buffer entries.
REQ-002 Ports SHALL be, one per line:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset
 cfg_we  in  1  modulus table write strobe
 cfg_idx  in  $clog2(NUM_MOD)  table write index
 cfg_modulus  in  WIDTH  table write data
 in_valid  in  1  input beat valid
 in_ready  out  1  input beat accepted when in_valid&in_ready
 in_op  in  2  0 MUL, 1 ADD, 2 SUB, 3 MAC
 in_first  in  1  MAC: clear accumulator before this beat
 in_mod_sel  in  $clog2(NUM_MOD)  modulus table entry for this beat
 in_a  in  WIDTH*LANES  operand A, lane i at bits [(i+1)*WIDTH-1 -: WIDTH]
 in_b  in  WIDTH*LANES  operand B, same packing
 out_valid  out  1  output beat valid
 out_ready  in  1  output beat consumed when out_valid&out_ready
 out_data  out  WIDTH*LANES  result, same packing
 busy  out  1  any beat in pipeline or output buffer
 err_range  out  1  sticky operand/modulus error flag
 err_clr  in  1  clears err_range

Function
REQ-003 Per lane, with q = table[in_mod_sel] sampled at acceptance: MUL a*b mod q; ADD (a+b) mod q; SUB (a-b) mod q in [0,q-1]; MAC acc = (acc + a*b) mod q, output = new acc.
REQ-004 Modulus SHALL travel with the beat; a cfg write at cycle t SHALL affect only beats accepted at t+1 or later.
REQ-005 All ops SHALL share one pipeline of MODMUL_DELAY+1 stages; ADD/SUB results delayed to match, so output order equals acceptance order.
REQ-006 Latency: beat accepted at cycle t with empty output buffer SHALL show out_valid at t+MODMUL_DELAY+1.
REQ-007 MAC accumulate SHALL occur in final stage, one per-lane accumulator, so back-to-back MAC beats chain without bubbles; in_first=1 uses acc=0.
REQ-008 Non-MAC beats SHALL not modify accumulators.
REQ-009 Credit count = beats in pipeline + buffer; in_ready = (count < OBUF_DEPTH); accept increments, pop decrements, both same cycle leaves count unchanged.
REQ-010 Output buffer SHALL be first-word-fall-through; out_data stable while out_valid&!out_ready.
REQ-011 No beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-012 If any lane operand >= q, or q < 2: that lane outputs 0, accumulator for that lane unchanged, err_range set at output time.
REQ-013 err_range SHALL remain set until err_clr; simultaneous set and err_clr leaves it set.
REQ-014 busy = (count != 0).

Reset
REQ-015 While reset low: in_ready=0, out_valid=0, busy=0, err_range=0, count=0, pipeline valids cleared, accumulators=0, modulus table=0.
REQ-016 First rising edge after reset release SHALL see in_ready=1.
REQ-017 Reset mid-operation SHALL discard all in-flight beats; data registers need not be cleared.

Structure
REQ-018 Op encodings, default parameter values and the lane packing macro SHALL live in the shared defines package alongside MODRED_DELAY/INTMUL_DELAY.
REQ-019 One sub-module, modop_lane (single-lane op + MAC stage), SHALL be instantiated LANES times; control/credit/buffer logic stays in modop_stream.

Verification
REQ-020 q=4244570881 in entry 0; MUL a=2,b=3 all lanes -> 6 at t+MODMUL_DELAY+1.
REQ-021 MUL a=b=q-1 -> 1; SUB a=0,b=1 -> 4244570880; ADD a=q-1,b=1 -> 0.
REQ-022 MAC in_first=1 a=2,b=3 then in_first=0 a=4,b=5 back-to-back -> 6 then 26; next in_first=1 a=1,b=1 -> 1.
REQ-023 out_ready low, push beats 1..OBUF_DEPTH+2: in_ready drops after OBUF_DEPTH accepts; release -> exactly OBUF_DEPTH beats in order; random out_ready 1000 beats vs model, no loss.
REQ-024 Lane 3 a=q, others valid -> lane 3 = 0, err_range=1 until err_clr; cfg write entry 1 at t, beat at t selecting entry 1 uses old value.
REQ-025 Reset low with 4 beats in flight -> out_valid=0, busy=0 immediately; after release in_ready=1, no stale output.
